mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu.sv | 178 +++++++++++++++++
 tb/tb_mc_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add
// multiply, registered result and flags held until the consumer accepts.
module mc_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [2:0]     OP_ADD = 3'b000;
  localparam logic [2:0]     OP_SUB = 3'b001;
  localparam logic [2:0]     OP_AND = 3'b010;
  localparam logic [2:0]     OP_NOT = 3'b011;
  localparam logic [2:0]     OP_OR  = 3'b100;
  localparam logic [2:0]     OP_XOR = 3'b101;
  localparam logic [2:0]     OP_SHL = 3'b110;
  localparam logic [2:0]     OP_MUL = 3'b111;
  localparam logic [SHW-1:0] LAST_BIT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH:0]       add_full, sub_full, shl_full;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_v, alu_c;
  logic [2*WIDTH-1:0]   acc_step;

  // Handshake: flush blocks acceptance; DONE can hand off and accept on one edge
  assign in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign out       = out_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign C         = c_q;

  // Single-cycle ops; the extra top bit of each wide result is carry/borrow/shifted-out bit
  always_comb begin
    add_full = {1'b0, Ain} + {1'b0, Bin};
    sub_full = {1'b0, Ain} - {1'b0, Bin};
    shl_full = {1'b0, Ain} << Bin[SHW-1:0];
    alu_res  = '0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (add_full[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];
        alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (sub_full[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND: alu_res = Ain & Bin;
      OP_NOT: alu_res = ~Bin;
      OP_OR:  alu_res = Ain | Bin;
      OP_XOR: alu_res = Ain ^ Bin;
      OP_SHL: begin
        // Bit shifted out last always lands at position WIDTH; zero for a shift of 0
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      default: ;
    endcase
  end

  // One multiplier bit per cycle: add shifted multiplicand when the LSB is set
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and datapath: flush first, then acceptance, then per-state progress
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    c_d      = c_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      if (ALUop == OP_MUL) begin
        state_d  = S_MUL;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, Ain};
        mplier_d = Bin;
        cnt_d    = '0;
      end else begin
        state_d = S_DONE;
        out_d   = alu_res;
        z_d     = (alu_res == '0);
        n_d     = alu_res[WIDTH-1];
        v_d     = alu_v;
        c_d     = alu_c;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = S_DONE;
            out_d   = acc_step[WIDTH-1:0];
            z_d     = (acc_step[WIDTH-1:0] == '0);
            n_d     = acc_step[WIDTH-1];
            v_d     = |acc_step[2*WIDTH-1:WIDTH];
            c_d     = 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        S_IDLE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Testbench for mc_alu: directed corner cases plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mc_alu;

  localparam int W   = 16;
  localparam int SHW = 4;

  logic         clk = 1'b0;
  logic         reset_n, in_valid, in_ready, flush;
  logic [W-1:0] Ain, Bin, out;
  logic [2:0]   ALUop;
  logic         Z, N, V, C, out_valid, out_ready, busy;

  int vectors = 0;
  int miscompares = 0;

  // Model state: result pending/visible, remaining multiply cycles, expected result
  int           m_left  = 0;
  bit           m_valid = 1'b0;
  logic [W+3:0] m_res   = '0;
  logic [W+3:0] m_pend  = '0;

  mc_alu #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .flush(flush), .out(out),
    .Z(Z), .N(N), .V(V), .C(C), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {out, Z, N, V, C} from plain integer arithmetic
  function automatic logic [W+3:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W-1:0] as_, bs_;
    longint ua, ub, sa, sb, full, s;
    logic [W-1:0] r;
    logic v, c;
    int sh;
    as_ = a; bs_ = b;
    ua = a; ub = b; sa = as_; sb = bs_;
    v = 1'b0; c = 1'b0; r = '0;
    case (op)
      3'd0: begin
        full = ua + ub; r = W'(full); c = (full >= (64'sd1 << W));
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        r = W'(ua - ub); c = (ua >= ub);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        sh = int'(ub % W); full = ua << sh; r = W'(full);
        c = (sh == 0) ? 1'b0 : (((ua >> (W - sh)) & 1) != 0);
      end
      default: begin
        full = ua * ub; r = W'(full); v = ((full >> W) != 0);
      end
    endcase
    return {r, (r == '0), r[W-1], v, c};
  endfunction

  // Transaction model, advanced on each clock edge from the sampled inputs
  always @(posedge clk or negedge reset_n) begin
    bit rdy;
    if (!reset_n) begin
      m_left = 0; m_valid = 1'b0; m_res = '0;
    end else begin
      rdy = !flush && ((m_left == 0 && !m_valid) || (m_valid && out_ready));
      if (flush) begin
        m_left = 0; m_valid = 1'b0;
      end else if (in_valid && rdy) begin
        if (ALUop == 3'd7) begin
          m_pend = ref_alu(ALUop, Ain, Bin); m_left = W; m_valid = 1'b0;
        end else begin
          m_res = ref_alu(ALUop, Ain, Bin); m_valid = 1'b1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_res = m_pend; m_valid = 1'b1; end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !flush && ((m_left == 0 && !m_valid) || (m_valid && out_ready));
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, (m_left > 0));
    chk("out", out, m_res[W+3:4]);
    chk("flags_znvc", {Z, N, V, C}, m_res[3:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return W'($urandom_range(0, 16));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; ALUop = op; Ain = a; Bin = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int edges, busy_cnt;
    reset_n = 1'b0; in_valid = 1'b0; Ain = '0; Bin = '0; ALUop = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out", out, 16'h0000);
    chk("rst_flags", {Z, N, V, C}, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // First request on the first edge after reset release, then back-to-back ops
    reset_n = 1'b1;
    req(3'd0, 16'h7FFF, 16'h0001);
    chk("add_ovf_out", out, 16'h8000);
    chk("add_ovf_flags", {Z, N, V, C}, 4'b0110);
    chk("add_ovf_valid", out_valid, 1'b1);
    req(3'd1, 16'h0005, 16'h0005);
    chk("sub_eq_out", out, 16'h0000);
    chk("sub_eq_flags", {Z, N, V, C}, 4'b1001);
    req(3'd1, 16'h0000, 16'h0001);
    chk("sub_neg_out", out, 16'hFFFF);
    chk("sub_neg_flags", {Z, N, V, C}, 4'b0100);
    req(3'd6, 16'h8001, 16'h0001);
    chk("shl_out", out, 16'h0002);
    chk("shl_flags", {Z, N, V, C}, 4'b0001);

    // Multiply: busy for W cycles, result exactly W edges after acceptance
    req(3'd7, 16'h0100, 16'h0100);
    busy_cnt = busy ? 1 : 0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick(); edges++;
      if (busy) busy_cnt++;
    end
    chk("mul_latency", edges, W);
    chk("mul_busy_cycles", busy_cnt, W);
    chk("mul_out", out, 16'h0000);
    chk("mul_flags", {Z, N, V, C}, 4'b1010);

    // Back-pressure: result held while out_ready low, then same-edge handoff
    req(3'd0, 16'h0003, 16'h0004);
    out_ready = 1'b0;
    in_valid = 1'b1; ALUop = 3'd0; Ain = 16'h0001; Bin = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out", out, 16'h0007);
      chk("hold_flags", {Z, N, V, C}, 4'b0000);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("handoff_out", out, 16'h0002);
    chk("handoff_valid", out_valid, 1'b1);

    // Flush mid-multiply
    req(3'd7, 16'h1234, 16'h0003);
    repeat (6) tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_keep_out", out, 16'h0002);
    req(3'd0, 16'h0002, 16'h0003);
    chk("post_flush_add", out, 16'h0005);
    chk("post_flush_valid", out_valid, 1'b1);

    // Asynchronous reset mid-multiply
    req(3'd7, 16'h1234, 16'h0003);
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    chk("amid_rst_out", out, 16'h0000);
    chk("amid_rst_flags", {Z, N, V, C}, 4'b0000);
    chk("amid_rst_valid", out_valid, 1'b0);
    chk("amid_rst_busy", busy, 1'b0);
    tick();
    reset_n = 1'b1;
    req(3'd0, 16'h0002, 16'h0003);
    chk("post_rst_add", out, 16'h0005);
    chk("post_rst_valid", out_valid, 1'b1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      ALUop     = 3'($urandom_range(0, 7));
      Ain       = rand_opnd();
      Bin       = rand_opnd();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      reset_n   = ($urandom_range(0, 399) != 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; reset_n = 1'b1; out_ready = 1'b1;
    repeat (W + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
